// File: rtl/ram_port_arbiter.sv
// Arbiter sharing BRAM port B between the core (C) and the loader/DMA (L).
// The core has priority; the loader may lock bursts; wait counters prevent starvation.
module ram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [3:0]        c_wstrb,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [3:0]        l_wstrb,
  input  logic [31:0]       l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [31:0]       l_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_wstrb,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CORE,
    S_LOAD,
    S_LOCK
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cw;
  logic [CNT_W-1:0] lw;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A lock only holds off the core until its counter saturates.
  always_comb begin
    c_gnt      = 1'b0;
    l_gnt      = 1'b0;
    next_state = S_IDLE;
    if (resetb) begin
      if (c_req && l_req) begin
        if (state == S_LOCK && cw < MAX_CNT) begin
          l_gnt = 1'b1;
        end else if (lw == MAX_CNT) begin
          l_gnt = 1'b1;
        end else begin
          c_gnt = 1'b1;
        end
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
    if (c_gnt) begin
      next_state = S_CORE;
    end else if (l_gnt) begin
      next_state = l_lock ? S_LOCK : S_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      cw <= '0;
      lw <= '0;
    end else begin
      if (c_req && !c_gnt) begin
        if (cw != MAX_CNT) cw <= cw + 1'b1;
      end else begin
        cw <= '0;
      end
      if (l_req && !l_gnt) begin
        if (lw != MAX_CNT) lw <= lw + 1'b1;
      end else begin
        lw <= '0;
      end
    end
  end

  always_comb begin
    ram_addr  = c_addr;
    ram_wstrb = 4'b0000;
    ram_wdata = 32'h0;
    if (c_gnt) begin
      ram_addr  = c_addr;
      ram_wstrb = c_wstrb;
      ram_wdata = c_wdata;
    end else if (l_gnt) begin
      ram_addr  = l_addr;
      ram_wstrb = l_wstrb;
      ram_wdata = l_wdata;
    end
  end

  // Read data arrives one cycle after the grant, so rvalid is the registered read grant.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
    end else begin
      c_rvalid <= c_gnt && (c_wstrb == 4'b0000);
      l_rvalid <= l_gnt && (l_wstrb == 4'b0000);
    end
  end

  assign c_rdata = ram_rdata;
  assign l_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural BRAM port B attached.
module tb_ram_port_arbiter;

  logic        clk;
  logic        resetb;
  logic        c_req;
  logic [13:0] c_addr;
  logic [3:0]  c_wstrb;
  logic [31:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        l_req;
  logic [13:0] l_addr;
  logic [3:0]  l_wstrb;
  logic [31:0] l_wdata;
  logic        l_lock;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;
  logic [13:0] ram_addr;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:16383];

  int checks = 0;
  int passes = 0;

  ram_port_arbiter #(.ADDR_W(14), .MAX_WAIT(8)) dut (
    .clk(clk), .resetb(resetb),
    .c_req(c_req), .c_addr(c_addr), .c_wstrb(c_wstrb), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wstrb(l_wstrb), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .ram_addr(ram_addr), .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM port with byte write enables.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rb, input logic cr, input logic lr, input logic lk);
    resetb = rb;
    c_req  = cr;
    l_req  = lr;
    l_lock = lk;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEADBEEF;
    mem[4]  = 32'h11223344;
    c_addr  = 14'h3000;
    c_wstrb = 4'hF;
    c_wdata = 32'h0;
    l_addr  = 14'h3001;
    l_wstrb = 4'hF;
    l_wdata = 32'h0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 2; i++) begin
      nextCycle();
      checkOutput("rst_c_gnt", 32'(c_gnt), 0);
      checkOutput("rst_l_gnt", 32'(l_gnt), 0);
      checkOutput("rst_ram_wstrb", 32'(ram_wstrb), 0);
      checkOutput("rst_c_rvalid", 32'(c_rvalid), 0);
      checkOutput("rst_l_rvalid", 32'(l_rvalid), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_c_gnt", 32'(c_gnt), 1);
    checkOutput("post_rst_l_gnt", 32'(l_gnt), 0);

    nextCycle();
    c_addr  = 14'h0010;
    c_wstrb = 4'h0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("rd_c_gnt", 32'(c_gnt), 1);
    checkOutput("rd_ram_addr", 32'(ram_addr), 32'h10);
    checkOutput("rd_c_rvalid_after_wr", 32'(c_rvalid), 0);

    nextCycle();
    l_addr  = 14'h0004;
    l_wstrb = 4'b0010;
    l_wdata = 32'h0000AB00;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rd_c_rvalid", 32'(c_rvalid), 1);
    checkOutput("rd_c_rdata", c_rdata, 32'hDEADBEEF);
    checkOutput("rd_l_rvalid", 32'(l_rvalid), 0);
    checkOutput("wr_l_gnt", 32'(l_gnt), 1);
    checkOutput("wr_c_gnt", 32'(c_gnt), 0);
    checkOutput("wr_ram_wstrb", 32'(ram_wstrb), 32'h2);
    checkOutput("wr_ram_wdata", ram_wdata, 32'h0000AB00);

    nextCycle();
    l_wstrb = 4'h0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("wr_no_rvalid", 32'(l_rvalid), 0);
    checkOutput("l_rd_gnt", 32'(l_gnt), 1);
    checkOutput("l_rd_ram_addr", 32'(ram_addr), 32'h4);

    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("l_rvalid", 32'(l_rvalid), 1);
    checkOutput("l_rdata_byte1", l_rdata, 32'h1122AB44);
    checkOutput("l_rd_c_rvalid", 32'(c_rvalid), 0);
    checkOutput("idle_ram_wstrb", 32'(ram_wstrb), 0);
    checkOutput("idle_ram_addr", 32'(ram_addr), 32'h10);
    checkOutput("idle_ram_wdata", ram_wdata, 0);

    // Contention without lock: eight core grants, then one loader grant.
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) begin
      checkOutput($sformatf("cont_c_gnt_%0d", i), 32'(c_gnt), (i == 8 || i == 17) ? 0 : 1);
      checkOutput($sformatf("cont_l_gnt_%0d", i), 32'(l_gnt), (i == 8 || i == 17) ? 1 : 0);
      if (i == 7) checkOutput("cont_lw_7", 32'(dut.lw), 7);
      if (i == 8) checkOutput("cont_lw_peak", 32'(dut.lw), 8);
      if (i == 9) checkOutput("cont_l_rvalid", 32'(l_rvalid), 1);
      nextCycle();
      #1;
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("lock_start_l_gnt", 32'(l_gnt), 1);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("lock_l_gnt_%0d", i), 32'(l_gnt), (i < 8) ? 1 : 0);
      checkOutput($sformatf("lock_c_gnt_%0d", i), 32'(c_gnt), (i < 8) ? 0 : 1);
      if (i == 8) checkOutput("lock_cw_sat", 32'(dut.cw), 8);
      nextCycle();
      #1;
    end

    // Reset in the middle of a locked read burst.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("burst_l_gnt", 32'(l_gnt), 1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_rst_l_gnt", 32'(l_gnt), 0);
    checkOutput("mid_rst_wstrb", 32'(ram_wstrb), 0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("mid_rst_l_rvalid", 32'(l_rvalid), 0);
    checkOutput("mid_rst_c_gnt", 32'(c_gnt), 1);
    checkOutput("mid_rst_l_gnt_after", 32'(l_gnt), 0);

    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("drop_lw_before", 32'(dut.lw), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("drop_lw_cleared", 32'(dut.lw), 0);
    checkOutput("drop_c_gnt", 32'(c_gnt), 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
